fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
IF-stage next-PC generator sitting directly upstream of the branch target buffer. It drives the fetch PC into the BTB and picks the next PC from the BTB prediction (valid/target/predictedTaken). It keeps an in-flight prediction queue and resolves each entry against the EX-stage outcome. It drives the BTB update port (update/updatePC/updateTarget/mispredicted) and redirects fetch on a misprediction.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
QDEPTH, 4, in-flight prediction queue depth; power of 2, minimum 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  downstream fetch stall; holds PC and suppresses push
PC  out  32  current fetch address; feeds BTB read port and I-cache
fetch_valid  out  1  PC is a valid fetch this cycle (pushed into queue)
btb_valid  in  1  BTB hit for PC (combinational from PC)
btb_target  in  32  BTB predicted target
btb_taken  in  1  BTB predicted taken
ex_resolve  in  1  oldest in-flight instruction leaves EX this cycle
ex_is_branch  in  1  resolving instruction is a branch or jump
ex_taken  in  1  actual branch direction
ex_target  in  32  actual branch target
update  out  1  BTB write enable (registered)
updatePC  out  32  PC of resolved branch
updateTarget  out  32  actual target
mispredicted  out  1  resolved branch mispredicted
q_err  out  1  sticky: ex_resolve arrived with the queue empty

Behaviour:
- Reset (sync, rst=1 at posedge):
  - PC=RESET_PC; queue empty.
  - update, mispredicted and q_err = 0; updatePC and updateTarget = 0.
- pred_next = (btb_valid && btb_taken) ? btb_target : PC+4. Addition is 32-bit wrap-around; 32'hFFFF_FFFC+4 = 0.
- fetch_valid = !stall && !full && !redirect (combinational).
- Queue entries hold {pc, pred_next, pred_hit=btb_valid}.
  - Push when fetch_valid.
  - Pop at head when ex_resolve && !empty.
  - Simultaneous push and pop allowed when full: the pop frees the slot in the same cycle, so full is evaluated after the pop.
  - Pointers are log2(QDEPTH)+1 bits wide, wrapping.
- Resolution (combinational on head when ex_resolve && !empty):
  - actual_next = (ex_is_branch && ex_taken) ? ex_target : head.pc+4.
  - redirect = (actual_next != head.pred_next).
- PC register at posedge, in priority order:
  - rst → RESET_PC.
  - redirect → actual_next; queue flushed to empty; this cycle's fetch is not pushed.
  - fetch_valid → pred_next.
  - otherwise PC holds.
- BTB update, registered, 1-cycle latency after resolve:
  - Condition: ex_resolve && !empty && ex_is_branch && (ex_taken || head.pred_hit).
  - Next cycle: update=1, updatePC=head.pc, updateTarget=ex_target, mispredicted=redirect.
  - Otherwise update=0 and mispredicted=0; updatePC and updateTarget hold their last values.
- Non-branch that mispredicts (BTB aliasing, pred_next != pc+4):
  - Redirect occurs.
  - No update is generated, because ex_is_branch=0.
- ex_resolve with the queue empty:
  - Ignored: no pop, no redirect, no update.
  - q_err is set and stays set until rst.
- stall=1 and redirect in the same cycle: redirect wins; PC loads actual_next.
- rst asserted mid-flight discards all entries; no update is emitted in the cycle after reset.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_branches[31:0] and perf_mispred[31:0].
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - perf_branches increments on each resolved branch (ex_resolve && !empty && ex_is_branch).
  - perf_mispred increments on each redirect.
- Undefined: counters and ports are absent; all other behaviour is identical.

Test Plan:
1. Reset then free-run with no BTB hits, stall=0 → PC sequence 0,4,8,12; fetch_valid=1; queue fills to 4, then fetch_valid=0 until ex_resolve pops.
2. PC=0x40 with btb_valid=1, btb_taken=1, btb_target=0x100 → next PC=0x100. Resolve with ex_taken=1, ex_target=0x100 → no redirect; next cycle update=1, updatePC=0x40, updateTarget=0x100, mispredicted=0.
3. Branch at 0x20 predicted not-taken (miss), resolves taken to 0x80 → PC=0x80 next edge, queue empty; next cycle update=1, updatePC=0x20, updateTarget=0x80, mispredicted=1.
4. Branch at 0x30 predicted taken to 0x200 (hit), resolves not-taken → PC=0x34 next edge; update=1, updatePC=0x30, mispredicted=1.
5. ex_resolve with the queue empty → no PC change, update=0, q_err=1 and stays 1 until rst.
6. PC=0xFFFF_FFFC, no hit → next PC=0x0. Assert rst with 3 entries queued → PC=RESET_PC, the following ex_resolve sets q_err, no update.

Source files
------------

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: IF-stage next-PC generator in front of the BTB.
// Selects the next fetch PC from the BTB prediction, tracks in-flight
// predictions in a small queue, resolves the oldest entry against the EX
// outcome, redirects fetch on a mismatch and writes the BTB update port.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating branch and
// misprediction counters (perf_branches / perf_mispred).
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    output logic [31:0] PC,
    output logic        fetch_valid,
    input  logic        btb_valid,
    input  logic [31:0] btb_target,
    input  logic        btb_taken,
    input  logic        ex_resolve,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        update,
    output logic [31:0] updatePC,
    output logic [31:0] updateTarget,
    output logic        mispredicted,
    output logic        q_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispred
`endif
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(QDEPTH);

    logic [31:0] r_pc;
    logic [31:0] r_q_pc   [QDEPTH];
    logic [31:0] r_q_pred [QDEPTH];
    logic        r_q_hit  [QDEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        r_update;
    logic [31:0] r_update_pc;
    logic [31:0] r_update_tgt;
    logic        r_mispred;
    logic        r_q_err;

    logic [AW:0]   w_count;
    logic          w_empty;
    logic          w_pop;
    logic          w_full;
    logic [AW-1:0] w_head;
    logic [AW-1:0] w_tail;
    logic [31:0]   w_pred_next;
    logic [31:0]   w_actual_next;
    logic          w_redirect;
    logic          w_fetch;
    logic          w_upd;

    // Queue occupancy, resolution of the head entry and fetch qualification
    always_comb begin
        w_count       = r_wptr - r_rptr;
        w_empty       = (r_wptr == r_rptr);
        w_pop         = ex_resolve && !w_empty;
        // A pop in this cycle frees its slot for this cycle's push
        w_full        = (w_count == DEPTH_CNT) && !w_pop;
        w_head        = r_rptr[AW-1:0];
        w_tail        = r_wptr[AW-1:0];
        w_pred_next   = (btb_valid && btb_taken) ? btb_target : r_pc + 32'd4;
        w_actual_next = (ex_is_branch && ex_taken) ? ex_target
                                                   : r_q_pc[w_head] + 32'd4;
        w_redirect    = w_pop && (w_actual_next != r_q_pred[w_head]);
        w_fetch       = !stall && !w_full && !w_redirect;
        w_upd         = w_pop && ex_is_branch && (ex_taken || r_q_hit[w_head]);
    end

    // PC register and queue pointers: reset, redirect/flush, then normal fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= RESET_PC;
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_redirect) begin
            r_pc   <= w_actual_next;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_fetch) begin
                r_pc   <= w_pred_next;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Queue storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (w_fetch) begin
            r_q_pc[w_tail]   <= r_pc;
            r_q_pred[w_tail] <= w_pred_next;
            r_q_hit[w_tail]  <= btb_valid;
        end
    end

    // Registered BTB update port; address/target hold between updates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_update     <= 1'b0;
            r_mispred    <= 1'b0;
            r_update_pc  <= '0;
            r_update_tgt <= '0;
        end else begin
            r_update  <= w_upd;
            r_mispred <= w_upd && w_redirect;
            if (w_upd) begin
                r_update_pc  <= r_q_pc[w_head];
                r_update_tgt <= ex_target;
            end
        end
    end

    // Sticky flag for a resolve that arrives with nothing in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_err <= 1'b0;
        end else if (ex_resolve && w_empty) begin
            r_q_err <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_br;
    logic [31:0] r_perf_mp;

    // Saturating counters of resolved branches and redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_br <= '0;
            r_perf_mp <= '0;
        end else begin
            if (w_pop && ex_is_branch && (r_perf_br != '1)) begin
                r_perf_br <= r_perf_br + 32'd1;
            end
            if (w_redirect && (r_perf_mp != '1)) begin
                r_perf_mp <= r_perf_mp + 32'd1;
            end
        end
    end

    assign perf_branches = r_perf_br;
    assign perf_mispred  = r_perf_mp;
`endif

    assign PC           = r_pc;
    assign fetch_valid  = w_fetch;
    assign update       = r_update;
    assign updatePC     = r_update_pc;
    assign updateTarget = r_update_tgt;
    assign mispredicted = r_mispred;
    assign q_err        = r_q_err;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed scenarios plus a randomized run
// checked against a queue-based reference model of the fetch/resolve rules.
module tb_fetch_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 4;

    logic        clk = 1'b0;
    logic        rst, stall, btb_valid, btb_taken;
    logic [31:0] btb_target;
    logic        ex_resolve, ex_is_branch, ex_taken;
    logic [31:0] ex_target;
    logic [31:0] PC, updatePC, updateTarget;
    logic        fetch_valid, update, mispredicted, q_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispred;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_pc_gen #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .PC(PC), .fetch_valid(fetch_valid),
        .btb_valid(btb_valid), .btb_target(btb_target), .btb_taken(btb_taken),
        .ex_resolve(ex_resolve), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
        .ex_target(ex_target), .update(update), .updatePC(updatePC),
        .updateTarget(updateTarget), .mispredicted(mispredicted), .q_err(q_err)
`ifdef FETCH_PERF_CNT_EN
        , .perf_branches(perf_branches), .perf_mispred(perf_mispred)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] pred;
        bit          hit;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc   = RESET_PC;
    logic        m_upd  = 1'b0;
    logic [31:0] m_upc  = '0;
    logic [31:0] m_utgt = '0;
    logic        m_mis  = 1'b0;
    logic        m_qerr = 1'b0;
    logic [31:0] m_pb   = '0;
    logic [31:0] m_pm   = '0;

    function automatic logic [31:0] m_actual();
        if (ex_is_branch && ex_taken) return ex_target;
        return mq[0].pc + 32'd4;
    endfunction

    function automatic bit m_redirect();
        if (!(ex_resolve && mq.size() > 0)) return 1'b0;
        return m_actual() != mq[0].pred;
    endfunction

    function automatic bit exp_fv();
        int occ;
        occ = mq.size();
        if (ex_resolve && occ > 0) occ = occ - 1;
        return !stall && (occ < QDEPTH) && !m_redirect();
    endfunction

    // Advance one clock: model computed from pre-edge inputs, returns at negedge
    task automatic tick();
        bit          pop, redir, upd, fv, hit;
        logic [31:0] actual, pred, hpc, tgt;
        pop    = ex_resolve && mq.size() > 0;
        redir  = m_redirect();
        fv     = exp_fv();
        actual = pop ? m_actual() : 32'd0;
        hpc    = pop ? mq[0].pc : 32'd0;
        upd    = pop && ex_is_branch && (ex_taken || mq[0].hit);
        pred   = (btb_valid && btb_taken) ? btb_target : m_pc + 32'd4;
        hit    = btb_valid;
        tgt    = ex_target;
        @(posedge clk);
        if (rst) begin
            m_pc = RESET_PC; mq.delete();
            m_upd = 0; m_mis = 0; m_upc = '0; m_utgt = '0; m_qerr = 0;
            m_pb = '0; m_pm = '0;
        end else begin
            m_upd = upd;
            m_mis = upd && redir;
            if (upd) begin m_upc = hpc; m_utgt = tgt; end
            if (ex_resolve && !pop) m_qerr = 1'b1;
            if (pop && ex_is_branch && m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 1;
            if (redir && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 1;
            if (redir) begin
                m_pc = actual; mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (fv) begin
                    mq.push_back('{pc: m_pc, pred: pred, hit: hit});
                    m_pc = pred;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; stall = 0; btb_valid = 0; btb_taken = 0; btb_target = '0;
        ex_resolve = 0; ex_is_branch = 0; ex_taken = 0; ex_target = '0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); idle();
    endtask

    task automatic btb_hit(input logic [31:0] t);
        btb_valid = 1; btb_taken = 1; btb_target = t;
    endtask

    task automatic resolve(input logic br, input logic tk, input logic [31:0] t);
        ex_resolve = 1; ex_is_branch = br; ex_taken = tk; ex_target = t;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        do_reset(); #1;
        checks++; if (PC !== RESET_PC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", PC, RESET_PC); end
        checks++; if (update !== 1'b0 || mispredicted !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b%b exp=00", update, mispredicted); end
        checks++; if (updatePC !== 32'd0 || updateTarget !== 32'd0) begin errors++; $display("FAIL reset_upd_regs got=%h/%h exp=0/0", updatePC, updateTarget); end
        checks++; if (q_err !== 1'b0) begin errors++; $display("FAIL reset_qerr got=%b exp=0", q_err); end
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL reset_fv got=%b exp=1", fetch_valid); end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (PC !== 32'(4 * i)) begin errors++; $display("FAIL freerun_pc%0d got=%h exp=%h", i, PC, 32'(4 * i)); end
            checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL freerun_fv%0d got=%b exp=1", i, fetch_valid); end
            tick();
        end
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL full_fv got=%b exp=0", fetch_valid); end
        tick();
        checks++; if (PC !== 32'd16) begin errors++; $display("FAIL full_hold got=%h exp=10", PC); end
        resolve(0, 0, 32'd0); #1;
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL full_pop_push_fv got=%b exp=1", fetch_valid); end
        tick();
        checks++; if (PC !== 32'd20) begin errors++; $display("FAIL full_pop_push_pc got=%h exp=14", PC); end
        checks++; if (update !== 1'b0) begin errors++; $display("FAIL nonbranch_upd got=%b exp=0", update); end
    endtask

    task automatic test_btb_hit();
        do_reset();
        btb_hit(32'h40); tick();
        btb_hit(32'h100); #1;
        checks++; if (PC !== 32'h40) begin errors++; $display("FAIL hit_pc40 got=%h exp=40", PC); end
        tick(); idle();
        checks++; if (PC !== 32'h100) begin errors++; $display("FAIL hit_pc100 got=%h exp=100", PC); end
        resolve(1, 1, 32'h40); tick();
        resolve(1, 1, 32'h100); #1;
        checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL hit_noredir_fv got=%b exp=1", fetch_valid); end
        tick(); idle();
        checks++; if (update !== 1'b1 || mispredicted !== 1'b0) begin errors++; $display("FAIL hit_upd got=%b/%b exp=1/0", update, mispredicted); end
        checks++; if (updatePC !== 32'h40 || updateTarget !== 32'h100) begin errors++; $display("FAIL hit_upd_addr got=%h/%h exp=40/100", updatePC, updateTarget); end
        checks++; if (PC !== 32'h108) begin errors++; $display("FAIL hit_seq_pc got=%h exp=108", PC); end
        tick();
        checks++; if (update !== 1'b0 || updatePC !== 32'h40) begin errors++; $display("FAIL hit_upd_hold got=%b/%h exp=0/40", update, updatePC); end
    endtask

    task automatic test_mispredict_taken();
        do_reset();
        btb_hit(32'h20); tick(); idle();
        tick();
        resolve(1, 1, 32'h20); tick(); idle();
        resolve(1, 1, 32'h80); stall = 1; #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL mp_t_fv got=%b exp=0", fetch_valid); end
        tick(); idle();
        checks++; if (PC !== 32'h80) begin errors++; $display("FAIL mp_t_pc got=%h exp=80", PC); end
        checks++; if (update !== 1'b1 || mispredicted !== 1'b1) begin errors++; $display("FAIL mp_t_upd got=%b/%b exp=1/1", update, mispredicted); end
        checks++; if (updatePC !== 32'h20 || updateTarget !== 32'h80) begin errors++; $display("FAIL mp_t_addr got=%h/%h exp=20/80", updatePC, updateTarget); end
        stall = 1; resolve(1, 1, 32'h80); tick(); idle();
        checks++; if (q_err !== 1'b1 || update !== 1'b0) begin errors++; $display("FAIL mp_t_flush got=%b/%b exp=1/0", q_err, update); end
    endtask

    task automatic test_mispredict_not_taken();
        do_reset();
        btb_hit(32'h30); tick();
        btb_hit(32'h200); resolve(1, 1, 32'h30); tick(); idle();
        resolve(1, 0, 32'h200); tick(); idle();
        checks++; if (PC !== 32'h34) begin errors++; $display("FAIL mp_nt_pc got=%h exp=34", PC); end
        checks++; if (update !== 1'b1 || mispredicted !== 1'b1 || updatePC !== 32'h30) begin errors++; $display("FAIL mp_nt_upd got=%b/%b/%h exp=1/1/30", update, mispredicted, updatePC); end
    endtask

    task automatic test_aliasing_nonbranch();
        do_reset();
        btb_hit(32'h500); tick(); idle();
        resolve(0, 0, 32'h0); tick(); idle();
        checks++; if (PC !== 32'h4 || update !== 1'b0) begin errors++; $display("FAIL alias got=%h/%b exp=4/0", PC, update); end
    endtask

    task automatic test_q_empty();
        do_reset();
        stall = 1; resolve(1, 1, 32'h300); tick(); idle();
        checks++; if (PC !== RESET_PC || update !== 1'b0 || q_err !== 1'b1) begin errors++; $display("FAIL qempty got=%h/%b/%b exp=0/0/1", PC, update, q_err); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (q_err !== 1'b1) begin errors++; $display("FAIL qerr_sticky got=%b exp=1", q_err); end
        do_reset();
        checks++; if (q_err !== 1'b0) begin errors++; $display("FAIL qerr_clear got=%b exp=0", q_err); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        btb_hit(32'hFFFF_FFFC); tick(); idle();
        tick();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap got=%h exp=0", PC); end
        tick();
        rst = 1; resolve(1, 1, 32'h44); tick(); idle();
        checks++; if (PC !== RESET_PC || update !== 1'b0) begin errors++; $display("FAIL midrst got=%h/%b exp=0/0", PC, update); end
        stall = 1; resolve(1, 1, 32'h44); tick(); idle();
        checks++; if (q_err !== 1'b1 || update !== 1'b0) begin errors++; $display("FAIL midrst_flush got=%b/%b exp=1/0", q_err, update); end
    endtask

    // ---------------- randomized run vs model ----------------
    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            rst        = ($urandom_range(0, 99) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            btb_valid  = $urandom_range(0, 1);
            btb_taken  = $urandom_range(0, 1);
            btb_target = 32'($urandom_range(0, 255)) << 2;
            ex_resolve = ($urandom_range(0, 9) < 4);
            if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
                if (mq[0].pred == mq[0].pc + 32'd4) begin
                    ex_is_branch = $urandom_range(0, 1);
                    ex_taken = 0; ex_target = 32'($urandom_range(0, 255)) << 2;
                end else begin
                    ex_is_branch = 1; ex_taken = 1; ex_target = mq[0].pred;
                end
            end else begin
                ex_is_branch = $urandom_range(0, 1);
                ex_taken     = $urandom_range(0, 1);
                ex_target    = 32'($urandom_range(0, 255)) << 2;
            end
            #1;
            checks++; if (!rst && fetch_valid !== exp_fv()) begin errors++; $display("FAIL rnd_fv cyc=%0d got=%b exp=%b", n, fetch_valid, exp_fv()); end
            tick();
            checks++; if (PC !== m_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", n, PC, m_pc); end
            checks++; if (update !== m_upd || mispredicted !== m_mis) begin errors++; $display("FAIL rnd_upd cyc=%0d got=%b/%b exp=%b/%b", n, update, mispredicted, m_upd, m_mis); end
            checks++; if (updatePC !== m_upc || updateTarget !== m_utgt) begin errors++; $display("FAIL rnd_upd_addr cyc=%0d got=%h/%h exp=%h/%h", n, updatePC, updateTarget, m_upc, m_utgt); end
            checks++; if (q_err !== m_qerr) begin errors++; $display("FAIL rnd_qerr cyc=%0d got=%b exp=%b", n, q_err, m_qerr); end
`ifdef FETCH_PERF_CNT_EN
            checks++; if (perf_branches !== m_pb || perf_mispred !== m_pm) begin errors++; $display("FAIL rnd_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", n, perf_branches, perf_mispred, m_pb, m_pm); end
`endif
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_btb_hit();
        test_mispredict_taken();
        test_mispredict_not_taken();
        test_aliasing_nonbranch();
        test_q_empty();
        test_wrap_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
